// File: rtl/note_sequencer_pkg.sv
// Shared types and constants for the note sequencer.
package note_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN
  } state_e;

  localparam int unsigned NOTE_W_DEF = 7;
  localparam int unsigned WINDOW_DEF = 5;
  localparam logic [NOTE_W_DEF-1:0] END_MARK = 7'h7F;

endpackage

// File: rtl/note_sequencer_if.sv
// Note ROM bus: the sequencer drives the address, the ROM returns data one cycle later.
interface note_sequencer_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned NOTE_W = 7
);
  logic [ADDR_W-1:0] rom_addr_out;
  logic [NOTE_W-1:0] rom_data_in;

  modport master (output rom_addr_out, input rom_data_in);
  modport slave  (input rom_addr_out, output rom_data_in);
endinterface

// File: rtl/note_sequencer_beat_timer.sv
// Loadable down-counter; expiry strobe when it reaches zero and is not paused.
module beat_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             pause_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (!pause_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = !pause_i && (cnt_q == '0);

endmodule

// File: rtl/note_sequencer.sv
// Song playback scheduler: walks the note ROM one note per beat into the note window.
// Optional NOTE_SEQUENCER_LOOP_EN: restart the song at its base instead of draining.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int unsigned NOTE_W         = NOTE_W_DEF,
  parameter int unsigned WINDOW         = WINDOW_DEF,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TICKS_PER_BEAT = 25_000_000
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  input  logic [ADDR_W-1:0]        song_base_in,
  input  logic                     pause_in,
  input  logic                     abort_in,
  note_sequencer_if.master         rom,
  output logic [NOTE_W*WINDOW-1:0] notes_out,
  output logic                     shifting_out,
  output logic                     busy_out,
  output logic                     done_out,
  output logic [ADDR_W-1:0]        beat_count_out
);

  localparam int unsigned NW    = NOTE_W * WINDOW;
  localparam int unsigned CNT_W = $clog2(TICKS_PER_BEAT);
  localparam int unsigned DW    = $clog2(WINDOW + 1);
  // HOLD plus FETCH and WAIT make up one beat; DRAIN spends the whole beat waiting.
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(TICKS_PER_BEAT - 3);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(TICKS_PER_BEAT - 1);
  localparam logic [DW-1:0]    LAST_DRAIN = DW'(WINDOW - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NW-1:0]     notes_q, notes_d;
  logic [ADDR_W-1:0] beat_q, beat_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              shift_q, shift_d;
  logic              done_q, done_d;
  logic              tmr_load, tmr_expire, song_end;
  logic [CNT_W-1:0]  tmr_val;
`ifdef NOTE_SEQUENCER_LOOP_EN
  logic [ADDR_W-1:0] base_q, base_d;
`endif

  beat_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (clk_in),
    .rst_ni     (rst_in),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .pause_i    (pause_in),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    notes_d  = notes_q;
    beat_d   = beat_q;
    drain_d  = drain_q;
    shift_d  = 1'b0;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = HOLD_LOAD;
    song_end = 1'b0;
`ifdef NOTE_SEQUENCER_LOOP_EN
    base_d   = base_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          addr_d  = song_base_in;
          notes_d = '0;
          beat_d  = '0;
          state_d = ST_FETCH;
`ifdef NOTE_SEQUENCER_LOOP_EN
          base_d  = song_base_in;
`endif
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (rom.rom_data_in == '1) begin
          song_end = 1'b1;
        end else begin
          notes_d  = NW'({notes_q, rom.rom_data_in});
          shift_d  = 1'b1;
          beat_d   = beat_q + ADDR_W'(1);
          tmr_load = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr_expire) begin
          if (addr_q == '1) begin
            song_end = 1'b1;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DRAIN: begin
        if (tmr_expire) begin
          notes_d = NW'({notes_q, NOTE_W'(0)});
          shift_d = 1'b1;
          drain_d = drain_q + DW'(1);
          if (drain_q == LAST_DRAIN) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = DRAIN_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (song_end) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
      addr_d  = base_q;
      done_d  = 1'b1;
      state_d = ST_FETCH;
`else
      drain_d  = '0;
      tmr_load = 1'b1;
      tmr_val  = DRAIN_LOAD;
      state_d  = ST_DRAIN;
`endif
    end

    // Abort overrides whatever the state logic decided, including a start from IDLE.
    if (abort_in) begin
      state_d = ST_IDLE;
      addr_d  = addr_q;
      beat_d  = beat_q;
      notes_d = '0;
      shift_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      notes_q <= '0;
      beat_q  <= '0;
      drain_q <= '0;
      shift_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef NOTE_SEQUENCER_LOOP_EN
      base_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      notes_q <= notes_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
      shift_q <= shift_d;
      done_q  <= done_d;
`ifdef NOTE_SEQUENCER_LOOP_EN
      base_q  <= base_d;
`endif
    end
  end

  assign rom.rom_addr_out = addr_q;
  assign notes_out        = notes_q;
  assign shifting_out     = shift_q;
  assign done_out         = done_q;
  assign beat_count_out   = beat_q;
  assign busy_out         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with an 8-cycle beat; covers both NOTE_SEQUENCER_LOOP_EN builds.
module tb_note_sequencer;
  import note_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, pause, abort;
  logic [7:0]  base;
  logic [34:0] notes;
  logic        shifting, busy, done;
  logic [7:0]  beat;
  logic [6:0]  rom [256];
  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  note_sequencer_if #(.ADDR_W(8), .NOTE_W(7)) rom_if ();

  note_sequencer #(
    .NOTE_W(7), .WINDOW(5), .ADDR_W(8), .TICKS_PER_BEAT(8)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .song_base_in(base),
    .pause_in(pause), .abort_in(abort), .rom(rom_if.master),
    .notes_out(notes), .shifting_out(shifting), .busy_out(busy),
    .done_out(done), .beat_count_out(beat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_if.rom_data_in <= rom[rom_if.rom_addr_out];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_song(input logic [7:0] b);
    start = 1'b1;
    base  = b;
    tick();
    start = 1'b0;
  endtask

  task automatic abort_song();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  initial begin
    logic exp_sh;
    logic [7:0] exp_addr;
    for (int i = 0; i < 256; i++) rom[i] = 7'h00;
    rom[8'h10] = 7'h01; rom[8'h11] = 7'h02; rom[8'h12] = END_MARK;
    rom[8'h20] = 7'h05; rom[8'h21] = 7'h06; rom[8'h22] = 7'h07; rom[8'h23] = END_MARK;
    rom[8'hFE] = 7'h11; rom[8'hFF] = 7'h22; rom[8'h00] = 7'h33;
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; base = 8'h00;
    repeat (3) tick();
    check("rst busy", busy, 1'b0);
    check("rst notes", notes, 35'h0);
    check("rst addr", rom_if.rom_addr_out, 8'h00);
    check("rst beat", beat, 8'h00);
    check("rst shift", shifting, 1'b0);
    check("rst done", done, 1'b0);
    rst_n = 1'b1;
    tick();

`ifndef NOTE_SEQUENCER_LOOP_EN
    // Two notes, end mark, five drain beats.
    start_song(8'h10);
    for (int e = 1; e <= 62; e++) begin
      tick();
      exp_sh = (e == 2 || e == 10 || e == 26 || e == 34 || e == 42 || e == 50 || e == 58);
      check($sformatf("t1 shift@%0d", e), shifting, exp_sh);
      check($sformatf("t1 done@%0d", e), done, e == 58);
      if (e == 10) check("t1 notes two", notes, 35'h82);
      if (e == 42) check("t1 head note", notes[34:28], 7'h01);
    end
    check("t1 busy end", busy, 1'b0);
    check("t1 notes end", notes, 35'h0);
    check("t1 beats", beat, 8'd2);
`else
    start_song(8'h10);
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp_sh = (e == 2 || e == 10 || e == 20);
      check($sformatf("t1L shift@%0d", e), shifting, exp_sh);
      check($sformatf("t1L done@%0d", e), done, e == 18);
      if (e == 18) check("t1L addr reload", rom_if.rom_addr_out, 8'h10);
    end
    check("t1L notes", notes, 35'h4101);
    check("t1L busy", busy, 1'b1);
    abort_song();
`endif

    // Pause for 20 edges in the first HOLD.
    start_song(8'h20);
    for (int e = 1; e <= 31; e++) begin
      tick();
      exp_sh = (e == 2 || e == 30);
      check($sformatf("t2 shift@%0d", e), shifting, exp_sh);
      if (e >= 5 && e <= 24) check($sformatf("t2 beat@%0d", e), beat, 8'd1);
      if (e == 4) pause = 1'b1;
      if (e == 24) pause = 1'b0;
    end
    abort_song();

    // Abort after the second shift.
    start_song(8'h10);
    for (int e = 1; e <= 11; e++) tick();
    check("t3 beat pre", beat, 8'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3 busy", busy, 1'b0);
    check("t3 notes", notes, 35'h0);
    check("t3 done", done, 1'b0);
    for (int e = 0; e < 30; e++) begin
      tick();
      check($sformatf("t3 idle done@%0d", e), done | busy | shifting, 1'b0);
    end

    // Start while busy is ignored.
    start_song(8'h20);
    for (int e = 1; e <= 17; e++) begin
      if (e == 1 || e == 3) begin
        start = 1'b1;
        base  = 8'h40;
      end
      tick();
      start = 1'b0;
      exp_addr = (e < 8) ? 8'h20 : (e < 16) ? 8'h21 : 8'h22;
      check($sformatf("t4 addr@%0d", e), rom_if.rom_addr_out, exp_addr);
    end
    abort_song();
    start = 1'b1; abort = 1'b1; base = 8'h40;
    tick();
    start = 1'b0; abort = 1'b0;
    check("t4 start+abort busy", busy, 1'b0);
    check("t4 start+abort addr", rom_if.rom_addr_out, 8'h22);
    tick();
    check("t4 stays idle", busy, 1'b0);

    // Reset mid-HOLD, then normal playback.
    start_song(8'h10);
    for (int e = 1; e <= 5; e++) tick();
    check("t5 busy pre", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5 addr", rom_if.rom_addr_out, 8'h00);
    check("t5 notes", notes, 35'h0);
    check("t5 beat", beat, 8'h00);
    check("t5 flags", {busy, shifting, done}, 3'b000);
    start_song(8'h20);
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("t5 shift@%0d", e), shifting, e == 2);
      if (e == 2) check("t5 notes first", notes, 35'h05);
    end
    check("t5 beat first", beat, 8'd1);
    abort_song();

`ifndef NOTE_SEQUENCER_LOOP_EN
    // Address exhaustion without an end mark.
    start_song(8'hFE);
    for (int e = 1; e <= 58; e++) begin
      tick();
      exp_addr = (e < 8) ? 8'hFE : 8'hFF;
      check($sformatf("t6 addr@%0d", e), rom_if.rom_addr_out, exp_addr);
      exp_sh = (e == 2 || e == 10 || e == 24 || e == 32 || e == 40 || e == 48 || e == 56);
      check($sformatf("t6 shift@%0d", e), shifting, exp_sh);
      check($sformatf("t6 done@%0d", e), done, e == 56);
      if (e == 10) check("t6 notes two", notes, 35'h8A2);
    end
    check("t6 busy end", busy, 1'b0);
    check("t6 notes end", notes, 35'h0);
`else
    start_song(8'hFE);
    for (int e = 1; e <= 17; e++) begin
      tick();
      exp_addr = (e < 8 || e >= 16) ? 8'hFE : 8'hFF;
      check($sformatf("t6L addr@%0d", e), rom_if.rom_addr_out, exp_addr);
      check($sformatf("t6L done@%0d", e), done, e == 16);
    end
    abort_song();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
